// File: rtl/vram_write_ctrl.sv
// Write-side front end for the double-buffered 80x60 character frame buffer.
// Queues (x, y, char) requests, drains them as linear VRAM writes, and runs full-screen clears and buffer commits.
module vram_write_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int COLS       = 80,
    parameter int ROWS       = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_x,
    input  logic [5:0]  req_y,
    input  logic [7:0]  req_char,
    input  logic        clear_req,
    input  logic [7:0]  fill_char,
    input  logic        commit_req,
    output logic        a_wr,
    output logic [12:0] a_addr,
    output logic [7:0]  a_din,
    output logic        commit,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          PW        = AW + 1;
    localparam logic [12:0] COLS_W    = 13'(COLS);
    localparam logic [12:0] ROWS_W    = 13'(ROWS);
    localparam logic [12:0] LAST_ADDR = 13'(COLS * ROWS - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, COMMIT} state_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  ch;
    } entry_t;

    state_t      state;
    entry_t      mem [FIFO_DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] clear_mark;
    logic        clear_pend;
    logic        commit_pend;
    logic [12:0] clr_cnt;
    logic [7:0]  fill_q;
    logic [12:0] req_addr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        in_range;
    logic        accept;
    logic        push;
    logic        pop;
    logic        drain_ok;
    logic        clear_take;
    logic        commit_take;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready   = !fifo_full && !commit_pend;
    assign accept      = req_valid && req_ready;
    assign in_range    = ({6'd0, req_x} < COLS_W) && ({7'd0, req_y} < ROWS_W);
    assign push        = accept && in_range;
    assign req_addr    = {6'd0, req_x} + {7'd0, req_y} * COLS_W;
    assign head        = mem[rd_ptr[AW-1:0]];
    assign clear_take  = clear_req && !clear_pend && (state != CLEAR);
    assign commit_take = commit_req && !commit_pend;

    // Entries at or past clear_mark arrived after the pending clear and must wait for it.
    assign drain_ok    = !fifo_empty && !(clear_pend && (rd_ptr == clear_mark));
    assign pop         = (state == DRAIN) && drain_ok;
    assign busy        = !fifo_empty || clear_pend || commit_pend || (state != IDLE);

    // NOTE: the FIFO storage has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= entry_t'({req_addr, req_char});
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            clear_mark <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            if (clear_take)
                clear_mark <= wr_ptr + PW'(push);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (accept && !in_range && (err_cnt != 8'hff))
            err_cnt <= err_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clear_pend  <= 1'b0;
            commit_pend <= 1'b0;
            clr_cnt     <= '0;
            fill_q      <= '0;
            a_wr        <= 1'b0;
            a_addr      <= '0;
            a_din       <= '0;
            commit      <= 1'b0;
        end else begin
            a_wr   <= 1'b0;
            commit <= 1'b0;
            if (clear_take) begin
                clear_pend <= 1'b1;
                fill_q     <= fill_char;
            end
            if (commit_take)
                commit_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (drain_ok) begin
                        state <= DRAIN;
                    end else if (clear_pend) begin
                        state      <= CLEAR;
                        clear_pend <= 1'b0;
                        clr_cnt    <= '0;
                    end else if (fifo_empty && commit_pend) begin
                        state       <= COMMIT;
                        commit      <= 1'b1;
                        commit_pend <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        a_wr   <= 1'b1;
                        a_addr <= head.addr;
                        a_din  <= head.ch;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    a_wr   <= 1'b1;
                    a_addr <= clr_cnt;
                    a_din  <= fill_q;
                    if (clr_cnt == LAST_ADDR)
                        state <= IDLE;
                    else
                        clr_cnt <= clr_cnt + 13'd1;
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Directed bench for vram_write_ctrl: single writes, range errors, FIFO back-pressure,
// clear ordering, clear+commit sequencing and reset abort of a running clear.
module tb_vram_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_x;
    logic [5:0]  req_y;
    logic [7:0]  req_char;
    logic        clear_req;
    logic [7:0]  fill_char;
    logic        commit_req;
    logic        a_wr;
    logic [12:0] a_addr;
    logic [7:0]  a_din;
    logic        commit;
    logic        busy;
    logic [7:0]  err_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          last_acc;
    int          last_wait;
    int          commit_cnt = 0;
    int          commit_at_len = -1;
    logic        commit_with_wr = 1'b0;
    logic [20:0] wq[$];
    int          wt[$];

    vram_write_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_char   (req_char),
        .clear_req  (clear_req),
        .fill_char  (fill_char),
        .commit_req (commit_req),
        .a_wr       (a_wr),
        .a_addr     (a_addr),
        .a_din      (a_din),
        .commit     (commit),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every VRAM write and commit pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wr) begin
                wq.push_back({a_addr, a_din});
                wt.push_back(cyc);
            end
            if (commit) begin
                commit_cnt++;
                commit_at_len  = wq.size();
                commit_with_wr = a_wr;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] ent(input int a, input int d);
        return {a[12:0], d[7:0]};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int x, input int y, input int c);
        req_x     = x[6:0];
        req_y     = y[5:0];
        req_char  = c[7:0];
        req_valid = 1'b1;
        last_wait = 0;
        while (!req_ready && last_wait < 8000) begin
            @(negedge clk);
            last_wait++;
        end
        last_acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse(input logic clr, input logic cmt, input logic [7:0] fc);
        clear_req  = clr;
        commit_req = cmt;
        fill_char  = fc;
        @(negedge clk);
        clear_req  = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, busy, 0);
    endtask

    initial begin
        int mism;
        int first_stall;
        int leak;
        int cc0;
        int n;
        logic found;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_char   = '0;
        clear_req  = 1'b0;
        fill_char  = '0;
        commit_req = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_wr", a_wr, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_a_din", a_din, 0);
        check("rst_commit", commit, 0);
        check("rst_err", err_cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        @(negedge clk);

        // Single request: x=5,y=2 -> 165
        wq.delete(); wt.delete();
        send(5, 2, 8'h41);
        wait_idle("single_idle", 100);
        check("single_cnt", wq.size(), 1);
        check("single_ent", wq[0], ent(165, 8'h41));
        check("single_lat", wt[0] - last_acc, 2);

        // Out-of-range requests
        wq.delete(); wt.delete();
        send(80, 0, 8'h01);
        send(0, 60, 8'h02);
        repeat (4) @(negedge clk);
        check("bad_nowr", wq.size(), 0);
        check("bad_err2", err_cnt, 2);
        for (int i = 0; i < 300; i++) send(127, 63, i);
        check("bad_sat", err_cnt, 255);
        check("bad_ready", req_ready, 1);

        // Clear with 3 requests before and 2 after
        wq.delete(); wt.delete();
        send(1, 0, 8'h10);
        send(2, 0, 8'h11);
        send(3, 0, 8'h12);
        pulse(1'b1, 1'b0, 8'h20);
        send(10, 1, 8'hA0);
        send(79, 59, 8'hA1);
        wait_idle("clr_idle", 10000);
        check("clr_cnt", wq.size(), 4805);
        check("clr_pre0", wq[0], ent(1, 8'h10));
        check("clr_pre1", wq[1], ent(2, 8'h11));
        check("clr_pre2", wq[2], ent(3, 8'h12));
        mism = 0;
        for (int i = 0; i < 4800; i++) if (wq[3 + i] !== ent(i, 8'h20)) mism++;
        check("clr_data", mism, 0);
        check("clr_gapless", wt[4802] - wt[3], 4799);
        check("clr_post0", wq[4803], ent(90, 8'hA0));
        check("clr_post1", wq[4804], ent(4799, 8'hA1));

        // Burst of 12 while a clear runs: FIFO fills after 8
        wq.delete(); wt.delete();
        first_stall = -1;
        pulse(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            send(i, 3, 8'h30 + i);
            if (last_wait > 0 && first_stall < 0) first_stall = i;
        end
        wait_idle("burst_idle", 10000);
        check("burst_stall_at", first_stall, 8);
        check("burst_cnt", wq.size(), 4812);
        mism = 0;
        for (int k = 0; k < 12; k++) if (wq[4800 + k] !== ent(240 + k, 8'h30 + k)) mism++;
        check("burst_order", mism, 0);
        check("burst_cont", wt[4811] - wt[4800], 11);

        // Simultaneous clear and commit
        wq.delete(); wt.delete();
        cc0  = commit_cnt;
        leak = 0;
        n    = 0;
        pulse(1'b1, 1'b1, 8'h55);
        while (!commit && n < 6000) begin
            if (req_ready) leak++;
            @(negedge clk);
            n++;
        end
        #1;
        check("cc_ready_low", leak, 0);
        check("cc_pulses", commit_cnt - cc0, 1);
        check("cc_writes_before", commit_at_len, 4800);
        check("cc_no_wr", commit_with_wr, 0);
        @(negedge clk);
        check("cc_width", commit, 0);
        wait_idle("cc_idle", 100);

        // Request accepted in the same cycle as commit_req precedes the commit
        wq.delete(); wt.delete();
        req_x = 7'd5; req_y = 6'd5; req_char = 8'h77; req_valid = 1'b1;
        commit_req = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; commit_req = 1'b0;
        n = 0;
        while (!commit && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("sc_before", commit_at_len, 1);
        check("sc_ent", wq[0], ent(405, 8'h77));
        @(negedge clk);
        wait_idle("sc_idle", 100);

        // Reset aborts a clear at address 1000; pending commit is dropped
        cc0 = commit_cnt;
        pulse(1'b1, 1'b1, 8'h66);
        n = 0;
        while (!(a_wr && a_addr == 13'd1000) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        found = a_wr && (a_addr == 13'd1000);
        check("abort_reach", found, 1);
        rst = 1'b1;
        #1;
        check("abort_a_wr", a_wr, 0);
        check("abort_a_addr", a_addr, 0);
        check("abort_a_din", a_din, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wq.delete(); wt.delete();
        repeat (10) @(negedge clk);
        check("abort_nocommit", commit_cnt - cc0, 0);
        check("abort_nowr", wq.size(), 0);
        pulse(1'b1, 1'b0, 8'h07);
        wait_idle("abort_idle", 10000);
        check("abort_reclr_cnt", wq.size(), 4800);
        check("abort_reclr_first", wq[0], ent(0, 8'h07));
        check("abort_reclr_last", wq[4799], ent(4799, 8'h07));
        check("abort_nocommit2", commit_cnt - cc0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_write_ctrl.md
Name: vram_write_ctrl

Overview:
- Upstream write-side stage for the double-buffered character frame buffer (80x60 cells, 8-bit character code per cell).
- Accepts (x, y, char) write requests from the CPU/MMIO side and queues them in a small FIFO.
- Converts each request into linear VRAM writes (a_wr/a_addr/a_din) and runs a full-screen clear engine.
- Issues the one-cycle commit pulse that swaps buffers once all prior work has landed.

Parameters:
- FIFO_DEPTH, 8, request FIFO entries; power of two, minimum 2.
- COLS, 80, cells per row.
- ROWS, 60, rows per frame; COLS*ROWS must be <= 8192.

Ports:
- clk  input  1  single clock; also drives the frame buffer write port.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  write request valid.
- req_ready  output  1  request accepted when valid&&ready at a rising edge.
- req_x  input  7  column, 0..COLS-1.
- req_y  input  6  row, 0..ROWS-1.
- req_char  input  8  character code.
- clear_req  input  1  one-cycle pulse: fill the back buffer with fill_char.
- fill_char  input  8  fill value, sampled with clear_req.
- commit_req  input  1  one-cycle pulse: commit the back buffer after pending work.
- a_wr  output  1  VRAM write strobe (registered).
- a_addr  output  13  VRAM linear address (registered).
- a_din  output  8  VRAM write data (registered).
- commit  output  1  one-cycle buffer-swap pulse (registered).
- busy  output  1  FIFO non-empty, clear pending or active, or commit pending.
- err_cnt  output  8  saturating count of dropped out-of-range requests.

Behaviour:
- Reset (async, any state): FIFO emptied; state IDLE; clear_pend and commit_pend cleared.
  - a_wr=0, a_addr=0, a_din=0, commit=0, err_cnt=0, busy=0.
  - req_ready=1 once reset deasserts.
  - Reset during a clear aborts it; no commit is issued.
- req_ready is combinational: !fifo_full && !commit_pend.
- Range check at acceptance:
  - x>=COLS or y>=ROWS: the request is not enqueued, err_cnt increments (saturates at 255), and the handshake still completes.
- Address: a_addr = x + y*COLS, computed at acceptance and stored in the FIFO with the char. Maximum 4799 with defaults.
- States: IDLE, DRAIN, CLEAR, COMMIT.
  - IDLE -> DRAIN when the FIFO is non-empty.
  - IDLE -> CLEAR when the FIFO is empty and clear_pend=1.
  - IDLE -> COMMIT when the FIFO is empty, clear_pend=0 and commit_pend=1.
  - DRAIN: pops one entry per cycle; a_wr=1 with the stored addr/char next cycle. Returns to IDLE when the FIFO is empty.
  - CLEAR: 13-bit counter 0..COLS*ROWS-1, one write per cycle, a_din=latched fill_char. Exactly 4800 a_wr cycles with defaults. Then IDLE; clear_pend cleared on entry to CLEAR.
  - COMMIT: commit=1 for exactly one cycle with a_wr=0; commit_pend cleared; back to IDLE.
- Ordering:
  - Requests accepted before clear_req are written before the clear starts.
  - Requests accepted after clear_req are queued and written after the clear completes. They may be accepted while CLEAR runs.
  - commit_req freezes intake (req_ready=0) until commit fires. Every write accepted before commit_req lands before commit.
- Simultaneous clear_req and commit_req: clear runs first, then commit.
- A request accepted in the same cycle as commit_req precedes the commit.
- clear_req while clear_pend or in CLEAR: ignored.
- commit_req while commit_pend: ignored.
- Latency: request accepted at edge N with the FIFO empty and IDLE -> a_wr high in the cycle after edge N+2. Sustained throughput is 1 write/clock.
- a_wr=0 in every cycle outside DRAIN/CLEAR output cycles. a_addr/a_din hold their last values when a_wr=0.
- FIFO full: req_ready=0. No overflow and no lost entries.

Test Plan:
- Reset, then a single request x=5,y=2,char=0x41 -> exactly one a_wr cycle with a_addr=165, a_din=0x41, 2 clocks after acceptance; busy returns to 0.
- Burst of 12 valid requests with FIFO_DEPTH=8 and a_wr continuous -> req_ready drops when the FIFO is full; all 12 writes appear in order; none lost.
- Requests x=80,y=0 and x=0,y=60 -> no a_wr; err_cnt=2. Then 300 bad requests -> err_cnt saturates at 255.
- clear_req with fill_char=0x20, plus 3 requests queued before and 2 after -> 3 writes, then 4800 writes addr 0..4799 data 0x20, then the 2 writes. No gaps inside the clear.
- clear_req and commit_req in the same cycle -> 4800 clear writes, then one commit pulse with a_wr=0. req_ready=0 from commit_req until the commit cycle.
- Assert rst at clear address 1000 -> outputs immediately 0, commit never pulses, and after release a new clear starts from address 0.
